// File: rtl/d_e_reg.sv
// d_e_reg: Decode -> Execute pipeline register.
// Captures D-stage results each cycle and presents them to the E stage.
// Supports bubble insertion (stall), whole-register freeze (hold) and
// operand refresh from the write-back port while frozen.
module d_e_reg #(
    parameter logic [31:0] BUBBLE_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        hold,
    input  logic [31:0] D_pc,
    input  logic [31:0] D_instr,
    input  logic [31:0] D_rs_data,
    input  logic [31:0] D_rt_data,
    input  logic [31:0] D_ext,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [4:0]  D_wa,
    input  logic [1:0]  D_tnew,
    input  logic        W_we,
    input  logic [4:0]  W_wa,
    input  logic [31:0] W_wd,
    output logic [31:0] E_pc,
    output logic [31:0] E_instr,
    output logic [31:0] E_rs_data,
    output logic [31:0] E_rt_data,
    output logic [31:0] E_ext,
    output logic [4:0]  E_rs,
    output logic [4:0]  E_rt,
    output logic [4:0]  E_wa,
    output logic [1:0]  E_tnew
);

    logic [31:0] r_pc, r_instr, r_rs_data, r_rt_data, r_ext;
    logic [4:0]  r_rs, r_rt, r_wa;
    logic [1:0]  r_tnew;

    logic [1:0]  w_tnew_next;
    logic        w_rs_refresh;
    logic        w_rt_refresh;

    // Tnew seen from E is one less than from D (saturating); $0 never creates a hazard.
    always_comb begin
        w_tnew_next = 2'd0;
        if (D_wa != 5'd0 && D_tnew != 2'd0)
            w_tnew_next = D_tnew - 2'd1;
    end

    // Write-back hits on the held operands; rs and rt are checked independently.
    assign w_rs_refresh = W_we && (W_wa != 5'd0) && (W_wa == r_rs);
    assign w_rt_refresh = W_we && (W_wa != 5'd0) && (W_wa == r_rt);

    // Pipeline register: reset > hold (with refresh) > stall bubble > normal capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc      <= BUBBLE_PC;
            r_instr   <= NOP_INSTR;
            r_rs_data <= 32'd0;
            r_rt_data <= 32'd0;
            r_ext     <= 32'd0;
            r_rs      <= 5'd0;
            r_rt      <= 5'd0;
            r_wa      <= 5'd0;
            r_tnew    <= 2'd0;
        end else if (hold) begin
            // Everything else, including Tnew, stays frozen.
            if (w_rs_refresh) r_rs_data <= W_wd;
            if (w_rt_refresh) r_rt_data <= W_wd;
        end else if (stall) begin
            r_pc      <= BUBBLE_PC;
            r_instr   <= NOP_INSTR;
            r_rs_data <= 32'd0;
            r_rt_data <= 32'd0;
            r_ext     <= 32'd0;
            r_rs      <= 5'd0;
            r_rt      <= 5'd0;
            r_wa      <= 5'd0;
            r_tnew    <= 2'd0;
        end else begin
            r_pc      <= D_pc;
            r_instr   <= D_instr;
            r_rs_data <= D_rs_data;
            r_rt_data <= D_rt_data;
            r_ext     <= D_ext;
            r_rs      <= D_rs;
            r_rt      <= D_rt;
            r_wa      <= D_wa;
            r_tnew    <= w_tnew_next;
        end
    end

    assign E_pc      = r_pc;
    assign E_instr   = r_instr;
    assign E_rs_data = r_rs_data;
    assign E_rt_data = r_rt_data;
    assign E_ext     = r_ext;
    assign E_rs      = r_rs;
    assign E_rt      = r_rt;
    assign E_wa      = r_wa;
    assign E_tnew    = r_tnew;

endmodule

// File: tb/tb_d_e_reg.sv
// Bench for d_e_reg: directed plan steps followed by randomized traffic,
// all checked against a field-level model of the E register.
module tb_d_e_reg;

    logic        clk, reset, stall, hold;
    logic [31:0] D_pc, D_instr, D_rs_data, D_rt_data, D_ext;
    logic [4:0]  D_rs, D_rt, D_wa;
    logic [1:0]  D_tnew;
    logic        W_we;
    logic [4:0]  W_wa;
    logic [31:0] W_wd;
    logic [31:0] E_pc, E_instr, E_rs_data, E_rt_data, E_ext;
    logic [4:0]  E_rs, E_rt, E_wa;
    logic [1:0]  E_tnew;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc, instr, rsd, rtd, ext;
        logic [4:0]  rs, rt, wa;
        logic [1:0]  tnew;
    } e_t;

    e_t m;

    d_e_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .hold(hold),
        .D_pc(D_pc), .D_instr(D_instr), .D_rs_data(D_rs_data), .D_rt_data(D_rt_data),
        .D_ext(D_ext), .D_rs(D_rs), .D_rt(D_rt), .D_wa(D_wa), .D_tnew(D_tnew),
        .W_we(W_we), .W_wa(W_wa), .W_wd(W_wd),
        .E_pc(E_pc), .E_instr(E_instr), .E_rs_data(E_rs_data), .E_rt_data(E_rt_data),
        .E_ext(E_ext), .E_rs(E_rs), .E_rt(E_rt), .E_wa(E_wa), .E_tnew(E_tnew)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic e_t bubble_image();
        e_t b;
        b.pc = 32'h0000_3000; b.instr = 32'h0;
        b.rsd = 0; b.rtd = 0; b.ext = 0; b.rs = 0; b.rt = 0; b.wa = 0; b.tnew = 0;
        return b;
    endfunction

    // Expected effect of one rising edge, from the behavioural rules.
    task automatic model_edge();
        if (hold) begin
            if (W_we && W_wa != 0 && W_wa == m.rs) m.rsd = W_wd;
            if (W_we && W_wa != 0 && W_wa == m.rt) m.rtd = W_wd;
        end else if (stall) begin
            m = bubble_image();
        end else begin
            m.pc = D_pc; m.instr = D_instr; m.rsd = D_rs_data; m.rtd = D_rt_data;
            m.ext = D_ext; m.rs = D_rs; m.rt = D_rt; m.wa = D_wa;
            if (D_wa == 0) m.tnew = 0;
            else if (D_tnew == 0) m.tnew = 0;
            else m.tnew = D_tnew - 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    E_pc,            m.pc);
        chk({tag, ".instr"}, E_instr,         m.instr);
        chk({tag, ".rsd"},   E_rs_data,       m.rsd);
        chk({tag, ".rtd"},   E_rt_data,       m.rtd);
        chk({tag, ".ext"},   E_ext,           m.ext);
        chk({tag, ".rs"},    {27'd0, E_rs},   {27'd0, m.rs});
        chk({tag, ".rt"},    {27'd0, E_rt},   {27'd0, m.rt});
        chk({tag, ".wa"},    {27'd0, E_wa},   {27'd0, m.wa});
        chk({tag, ".tnew"},  {30'd0, E_tnew}, {30'd0, m.tnew});
    endtask

    // One clock edge: model follows the edge, outputs sampled 1 time unit later.
    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Reset pulse placed between edges; outputs must clear before any edge.
    task automatic reset_pulse(input string tag);
        #2;
        reset = 1'b1;
        #1;
        m = bubble_image();
        check_all(tag);
        reset = 1'b0;
    endtask

    task automatic setd(input logic [31:0] pc, instr, rsd, rtd, ext,
                        input logic [4:0] rs, rt, wa, input logic [1:0] tn);
        D_pc = pc; D_instr = instr; D_rs_data = rsd; D_rt_data = rtd; D_ext = ext;
        D_rs = rs; D_rt = rt; D_wa = wa; D_tnew = tn;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; hold = 1'b0;
        W_we = 1'b0; W_wa = 5'd0; W_wd = 32'd0;
        setd(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 2'd0);
        m = bubble_image();
        #3;
        check_all("rst0");
        reset = 1'b0;

        // 1: capture after reset release
        setd(32'h3004, 32'h3C01_1234, 32'h0, 32'h0, 32'h0000_1234, 5'd0, 5'd1, 5'd1, 2'd1);
        cyc("t1");
        chk("t1.pc_const",   E_pc,  32'h3004);
        chk("t1.ext_const",  E_ext, 32'h1234);
        chk("t1.tnew_const", {30'd0, E_tnew}, 32'd0);
        reset_pulse("t1.midrst");
        chk("t1.rst_pc_const", E_pc, 32'h3000);

        // 2: Tnew arithmetic and $0 rule
        setd(32'h3008, 32'h1, 32'h5, 32'h6, 32'h7, 5'd2, 5'd3, 5'd5, 2'd2);
        cyc("t2a");
        chk("t2a.tnew_const", {30'd0, E_tnew}, 32'd1);
        D_tnew = 2'd0;
        cyc("t2b");
        chk("t2b.tnew_const", {30'd0, E_tnew}, 32'd0);
        D_tnew = 2'd2; D_wa = 5'd0;
        cyc("t2c");
        chk("t2c.tnew_const", {30'd0, E_tnew}, 32'd0);
        D_tnew = 2'd3; D_wa = 5'd7;
        cyc("t2d");

        // 3: stall inserts a bubble, then normal capture resumes
        setd(32'h3010, 32'h2402_0005, 32'h1, 32'h2, 32'h5, 5'd0, 5'd2, 5'd2, 2'd1);
        stall = 1'b1;
        cyc("t3a");
        chk("t3a.pc_const", E_pc, 32'h3000);
        chk("t3a.wa_const", {27'd0, E_wa}, 32'd0);
        stall = 1'b0;
        cyc("t3b");
        chk("t3b.pc_const", E_pc, 32'h3010);

        // 4: hold with write-back refresh
        setd(32'h3020, 32'h0109_1821, 32'h11, 32'h22, 32'h0, 5'd8, 5'd9, 5'd3, 2'd1);
        cyc("t4load");
        hold = 1'b1; W_we = 1'b1; W_wa = 5'd8; W_wd = 32'hDEAD_BEEF;
        setd(32'h4444, 32'h5555, 32'h6666, 32'h7777, 32'h8888, 5'd1, 5'd2, 5'd3, 2'd2);
        cyc("t4a");
        chk("t4a.rsd_const", E_rs_data, 32'hDEAD_BEEF);
        chk("t4a.rtd_const", E_rt_data, 32'h22);
        chk("t4a.pc_const",  E_pc,      32'h3020);
        W_wa = 5'd0; W_wd = 32'h5;
        cyc("t4b");
        W_we = 1'b0; W_wa = 5'd9;
        cyc("t4c");
        chk("t4c.rtd_const", E_rt_data, 32'h22);
        W_we = 1'b1;
        cyc("t4d");
        chk("t4d.rtd_const", E_rt_data, 32'h5);

        // 5: hold beats stall, then stall alone bubbles
        W_we = 1'b0; stall = 1'b1;
        for (int i = 0; i < 3; i++) cyc("t5hold");
        chk("t5.pc_const", E_pc, 32'h3020);
        hold = 1'b0;
        cyc("t5bub");
        chk("t5bub.pc_const", E_pc, 32'h3000);
        stall = 1'b0;

        // 6: same-index refresh, then reset during hold
        setd(32'h3030, 32'h0084_2020, 32'h1, 32'h2, 32'h0, 5'd4, 5'd4, 5'd4, 2'd2);
        cyc("t6load");
        hold = 1'b1; W_we = 1'b1; W_wa = 5'd4; W_wd = 32'h7;
        cyc("t6a");
        chk("t6a.rsd_const", E_rs_data, 32'h7);
        chk("t6a.rtd_const", E_rt_data, 32'h7);
        reset_pulse("t6rst");
        hold = 1'b0; W_we = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            setd($urandom, $urandom, $urandom, $urandom, $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 3)), 2'($urandom));
            hold  = ($urandom_range(0, 3) == 0);
            stall = ($urandom_range(0, 3) == 0);
            W_we  = $urandom_range(0, 1) == 1;
            W_wa  = ($urandom_range(0, 1) == 1) ? m.rs : 5'($urandom_range(0, 7));
            W_wd  = $urandom;
            if ($urandom_range(0, 49) == 0) reset_pulse("rnd.rst");
            else cyc("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/d_e_reg.md
Name: d_e_reg

Overview:
- Pipeline register between the Decode stage and the Execute stage of the 5-stage MIPS core.
- Captures the D-stage results each cycle: PC, instruction, GPR operands, the 32-bit immediate/shamt extension result, register indices, and the hazard-timing field.
- Presents them to the E-stage ALU, MDU and forwarding muxes.
- Supports three operations: stall-bubble insertion, whole-register hold (E-stage MDU busy), and operand refresh from the write-back port while held.

Parameters:
- BUBBLE_PC, 32'h0000_3000: PC value loaded on reset and on bubble insertion.
- NOP_INSTR, 32'h0000_0000: instruction word loaded on reset and on bubble insertion (sll $0,$0,0).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  D-stage stall from the hazard unit: load a bubble into E.
- hold  input  1  E-stage freeze, asserted while the MDU is busy and an MDU op waits in E.
- D_pc  input  32  PC of the instruction in D.
- D_instr  input  32  instruction in D.
- D_rs_data  input  32  forwarded rs operand in D.
- D_rt_data  input  32  forwarded rt operand in D.
- D_ext  input  32  extension-unit output in D.
- D_rs  input  5  rs index.
- D_rt  input  5  rt index.
- D_wa  input  5  destination GPR index (0 = no write).
- D_tnew  input  2  cycles until the result is ready, measured from D.
- W_we  input  1  GRF write enable at W.
- W_wa  input  5  GRF write address at W.
- W_wd  input  32  GRF write data at W.
- E_pc, E_instr, E_rs_data, E_rt_data, E_ext  output  32 each  registered copies of the D fields.
- E_rs, E_rt, E_wa  output  5 each  registered indices.
- E_tnew  output  2  registered Tnew as seen from E.

Behaviour:
Reset (async, highest priority). All outputs take these values immediately, independent of clk:
- E_pc = BUBBLE_PC
- E_instr = NOP_INSTR
- all other outputs = 0

Per rising edge, with reset low, the priority is hold > stall > normal.

Normal (hold=0, stall=0):
- Every E_* field takes its D_* field.
- E_tnew = (D_tnew == 0) ? 0 : D_tnew - 1 (saturating decrement).
- If D_wa == 0, then E_tnew = 0, since writes to $0 never create a hazard.

Bubble (hold=0, stall=1):
- Load the reset image: E_pc = BUBBLE_PC, E_instr = NOP_INSTR, everything else 0.
- D inputs are ignored.

Hold (hold=1, any stall):
- All fields retain their values, except the refresh rule below.

Refresh (only while hold=1):
- If W_we=1, W_wa!=0 and W_wa==E_rs, then E_rs_data ← W_wd.
- The same rule applies independently for E_rt / E_rt_data.
- Both may update in the same cycle; when E_rs==E_rt, both receive W_wd.
- E_tnew is NOT decremented during hold; the hazard unit owns hold timing.
- No refresh occurs when hold=0; the E-stage forwarding muxes cover that case.

General rules:
- Latency: exactly one cycle from D inputs to E outputs.
- No combinational path from any input to any output.
- hold=1 and stall=1 together: hold wins and no bubble is inserted. The hazard unit must keep D stalled.
- Reset asserted mid-hold or mid-stall: registers clear immediately. After release, the first edge behaves per the current stall/hold.
- No other state: no counters and no FSM beyond the register fields.

Test Plan:
1. Reset: assert reset between edges → outputs change immediately to E_pc=0x3000, E_instr=0, others 0. After release with D_pc=0x3004, D_instr=0x3C011234, D_ext=0x00001234, D_wa=1, D_tnew=1 → next edge E_pc=0x3004, E_ext=0x00001234, E_tnew=0.
2. Tnew arithmetic and $0 rule:
   - D_tnew=2, D_wa=5 → E_tnew=1.
   - D_tnew=0, D_wa=5 → E_tnew=0.
   - D_tnew=2, D_wa=0 → E_tnew=0.
3. Stall: stall=1 for one edge with a valid D instruction (D_pc=0x3010) → E_pc=0x3000, E_instr=0, E_wa=0. With stall=0 on the next edge → E_pc=0x3010.
4. Hold with refresh:
   - Load E_rs=8, E_rt=9, E_rs_data=0x11, E_rt_data=0x22, then hold=1.
   - W_we=1, W_wa=8, W_wd=0xDEADBEEF → E_rs_data=0xDEADBEEF, E_rt_data=0x22, E_pc unchanged.
   - W_wa=0 with W_wd=0x5 → no change.
   - W_we=0 → no change.
5. Hold versus stall: hold=1 and stall=1 together for 3 edges → all outputs frozen and no bubble inserted. Then hold=0, stall=1 → bubble.
6. Same-index refresh: E_rs=E_rt=4, hold=1, W_we=1, W_wa=4, W_wd=0x7 → both E_rs_data and E_rt_data become 0x7. Assert reset during this hold → all outputs clear asynchronously.
